spp_packetizer: RTL and testbench

- Downstream neighbour of the variable-delay stage in the gmrr sample path.
- Consumes the delay stage's AXI-stream output, whose tlast is unreliable during delay and advance events.
- Regenerates tlast so that no packet exceeds a programmable samples-per-packet (spp) limit.
- Optionally honours incoming tlast, and presents a registered output with one cycle of latency.

---
 rtl/spp_packetizer.sv | 127 ++++++++++++
 tb/tb_spp_packetizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spp_packetizer.sv
// spp_packetizer: regenerates tlast so that no packet exceeds spp samples, with one registered output stage.
// Optional statistics counters are enabled by defining SPP_PACKETIZER_STATS_EN.
//
// state  | meaning
// IDLE   | no packet open; the next accepted beat starts one and latches spp
// IN_PKT | packet open; cnt beats already passed, limit taken from spp_lat
module spp_packetizer #(
  parameter int MAX_LEN_LOG2 = 10,
  parameter int WIDTH        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [MAX_LEN_LOG2-1:0] spp,
  input  logic                    honor_tlast,
  input  logic [WIDTH-1:0]        i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
`ifdef SPP_PACKETIZER_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic [15:0]             short_count
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam logic [MAX_LEN_LOG2-1:0] ONE = MAX_LEN_LOG2'(1);

  state_t                  state, state_nxt;
  logic [MAX_LEN_LOG2-1:0] cnt, cnt_nxt;
  logic [MAX_LEN_LOG2-1:0] spp_lat, spp_lat_nxt;
  logic [MAX_LEN_LOG2-1:0] spp_eff;
  logic                    accept;
  logic                    end_spp;
  logic                    end_tlast;
  logic                    pkt_end;

  assign i_tready = ~o_tvalid | o_tready;
  assign accept   = i_tvalid & i_tready;

  // The live spp governs only the first beat; later beats use the latched copy.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    spp_lat_nxt = spp_lat;
    spp_eff     = (state == IDLE) ? spp : spp_lat;
    end_spp     = (spp_eff != '0) && (cnt == spp_eff - ONE);
    end_tlast   = honor_tlast & i_tlast;
    pkt_end     = end_spp | end_tlast;
    if (accept) begin
      if (state == IDLE) begin
        spp_lat_nxt = spp;
      end
      if (pkt_end) begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt   = cnt + ONE;
        state_nxt = IN_PKT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      spp_lat <= '0;
    end else if (clear) begin
      state   <= IDLE;
      cnt     <= '0;
      spp_lat <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      spp_lat <= spp_lat_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (clear) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (accept) begin
      o_tvalid <= 1'b1;
      o_tlast  <= pkt_end;
      o_tdata  <= i_tdata;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

`ifdef SPP_PACKETIZER_STATS_EN
  // A short packet is one closed by input tlast before the spp limit was reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count   <= '0;
      short_count <= '0;
    end else if (clear) begin
      pkt_count   <= '0;
      short_count <= '0;
    end else begin
      if (o_tvalid & o_tready & o_tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (accept & end_tlast & (spp_eff != '0) & ~end_spp) begin
        short_count <= short_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spp_packetizer.sv
// Directed self-checking bench for spp_packetizer; inputs change and outputs are sampled on the falling edge.
module tb_spp_packetizer;

  localparam int ML = 10;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [ML-1:0] spp;
  logic          honor_tlast;
  logic [W-1:0]  i_tdata;
  logic          i_tlast;
  logic          i_tvalid;
  logic          i_tready;
  logic [W-1:0]  o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready;
`ifdef SPP_PACKETIZER_STATS_EN
  logic [31:0]   pkt_count;
  logic [15:0]   short_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spp_packetizer #(.MAX_LEN_LOG2(ML), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .spp         (spp),
    .honor_tlast (honor_tlast),
    .i_tdata     (i_tdata),
    .i_tlast     (i_tlast),
    .i_tvalid    (i_tvalid),
    .i_tready    (i_tready),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_tvalid    (o_tvalid),
    .o_tready    (o_tready)
`ifdef SPP_PACKETIZER_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .short_count (short_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one beat at a falling edge and check it on the output one cycle later.
  task automatic beat(input logic [15:0] d, input logic tl, input logic exp_last, input string tag);
    i_tdata  = d;
    i_tlast  = tl;
    i_tvalid = 1'b1;
    #1;
    check($sformatf("%s_rdy_%0d", tag, d), 32'(i_tready), 32'd1);
    @(negedge clk);
    check($sformatf("%s_vld_%0d", tag, d), 32'(o_tvalid), 32'd1);
    check($sformatf("%s_data_%0d", tag, d), 32'(o_tdata), 32'(d));
    check($sformatf("%s_last_%0d", tag, d), 32'(o_tlast), 32'(exp_last));
  endtask

  task automatic idle_cycle(input string tag);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    @(negedge clk);
    check($sformatf("%s_idle_vld", tag), 32'(o_tvalid), 32'd0);
  endtask

  task automatic do_clear(input string tag);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check($sformatf("%s_clr_vld", tag), 32'(o_tvalid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            next_in;
    int            n_out;
    int            cyc;
    logic          stalled;
    logic          acc;
    logic [W-1:0]  held_d;
    logic          held_l;

    reset       = 1'b0;
    clear       = 1'b0;
    spp         = ML'(4);
    honor_tlast = 1'b0;
    i_tdata     = '0;
    i_tlast     = 1'b0;
    i_tvalid    = 1'b0;
    o_tready    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(o_tvalid), 32'd0);
    check("rst_last", 32'(o_tlast), 32'd0);
    check("rst_data", 32'(o_tdata), 32'd0);
    check("rst_rdy", 32'(i_tready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // spp=4, input tlast on beat 2 ignored because honor_tlast=0
    for (int k = 1; k <= 10; k++) beat(16'(k), (k == 2), (k % 4 == 0), "t1");
    idle_cycle("t1");

    // spp=8, honor_tlast: short packet at beat 3, then a full 8-beat packet ending at 11
    do_clear("t2");
    spp = ML'(8);
    honor_tlast = 1'b1;
    for (int k = 1; k <= 12; k++) beat(16'(k), (k == 3), (k == 3 || k == 11), "t2");
    idle_cycle("t2");
`ifdef SPP_PACKETIZER_STATS_EN
    check("t2_pkt_count", pkt_count, 32'd2);
    check("t2_short_count", 32'(short_count), 32'd1);
`endif

    // spp changed mid-packet only applies from the next packet
    do_clear("t3");
    spp = ML'(4);
    honor_tlast = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) spp = ML'(2);
      beat(16'(k), 1'b0, (k == 4 || k == 6 || k == 8), "t3");
    end
    idle_cycle("t3");

    // Coincident spp limit and input tlast: one tlast, counter restarts
    do_clear("tc");
    spp = ML'(4);
    honor_tlast = 1'b1;
    for (int k = 1; k <= 8; k++) beat(16'(k), (k == 4), (k == 4 || k == 8), "tc");
    idle_cycle("tc");

    // spp=1: every beat ends a packet
    do_clear("t1b");
    spp = ML'(1);
    honor_tlast = 1'b0;
    for (int k = 1; k <= 3; k++) beat(16'(k), 1'b0, 1'b1, "t1b");
    idle_cycle("t1b");

    // Backpressure with o_tready pattern 1,0,0 under continuous input
    do_clear("t4");
    spp = ML'(3);
    next_in = 1;
    n_out   = 0;
    cyc     = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    while (n_out < 12 && cyc < 100) begin
      o_tready = (cyc % 3 == 0);
      i_tvalid = 1'b1;
      i_tlast  = 1'b0;
      i_tdata  = 16'(next_in);
      #1;
      if (stalled) begin
        check("t4_hold_vld", 32'(o_tvalid), 32'd1);
        check("t4_hold_data", 32'(o_tdata), 32'(held_d));
        check("t4_hold_last", 32'(o_tlast), 32'(held_l));
      end
      if (o_tvalid && !o_tready) check("t4_rdy_low", 32'(i_tready), 32'd0);
      acc = i_tready;
      if (o_tvalid && o_tready) begin
        check("t4_data", 32'(o_tdata), 32'(n_out + 1));
        check("t4_last", 32'(o_tlast), 32'((n_out + 1) % 3 == 0));
        n_out++;
      end
      stalled = o_tvalid & ~o_tready;
      held_d  = o_tdata;
      held_l  = o_tlast;
      @(negedge clk);
      if (acc) next_in++;
      cyc++;
    end
    check("t4_count", 32'(n_out), 32'd12);
    o_tready = 1'b1;
    i_tvalid = 1'b0;
    @(negedge clk);

    // Clear drops a beat held under backpressure
    do_clear("tk");
    spp = ML'(4);
    beat(16'h55, 1'b0, 1'b0, "tk");
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    @(negedge clk);
    check("tk_held_vld", 32'(o_tvalid), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("tk_dropped_vld", 32'(o_tvalid), 32'd0);
    check("tk_dropped_data", 32'(o_tdata), 32'd0);
    o_tready = 1'b1;

    // spp=0, honor_tlast=0: never a tlast, counter wraps past 1024
    do_clear("t5a");
    spp = ML'(0);
    honor_tlast = 1'b0;
    for (int k = 1; k <= 2000; k++) beat(16'(k), (k % 100 == 0), 1'b0, "t5a");
    idle_cycle("t5a");

    // spp=0, honor_tlast=1: tlast follows the input every 100 beats
    do_clear("t5b");
    honor_tlast = 1'b1;
    for (int k = 1; k <= 2000; k++) beat(16'(k), (k % 100 == 0), (k % 100 == 0), "t5b");
    idle_cycle("t5b");

    // Reset mid-packet (cnt=2): the next beats open a fresh packet
    do_clear("t6");
    spp = ML'(4);
    honor_tlast = 1'b0;
    beat(16'd1, 1'b0, 1'b0, "t6pre");
    beat(16'd2, 1'b0, 1'b0, "t6pre");
    i_tvalid = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_rst_vld", 32'(o_tvalid), 32'd0);
    check("t6_rst_data", 32'(o_tdata), 32'd0);
    check("t6_rst_last", 32'(o_tlast), 32'd0);
    @(negedge clk);
    check("t6_rst_vld2", 32'(o_tvalid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) beat(16'(k + 20), 1'b0, (k == 4), "t6");
    idle_cycle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
